// File: rtl/spike_rate_decoder_if.sv
// Handshake/result bundle between a spike-rate decoder and its host.
// The master drives window control and spikes; the slave returns the results.
interface spike_rate_decoder_if #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 8
);
   logic                 start;
   logic                 cont;
   logic                 spike_in1;
   logic                 spike_in2;
   logic                 busy;
   logic [CNT_WIDTH-1:0] count_out1;
   logic [CNT_WIDTH-1:0] count_out2;
   logic [WIDTH-1:0]     rate_out1;
   logic [WIDTH-1:0]     rate_out2;
   logic [1:0]           winner;
   logic                 valid;

   modport master (
      output start, cont, spike_in1, spike_in2,
      input  busy, count_out1, count_out2, rate_out1, rate_out2, winner, valid
   );

   modport slave (
      input  start, cont, spike_in1, spike_in2,
      output busy, count_out1, count_out2, rate_out1, rate_out2, winner, valid
   );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes of two neurons over a fixed window and converts the counts to
// scaled rates, a winner code and a one-cycle valid pulse.
//
//   state | meaning
//   IDLE  | waiting for start, busy low
//   COUNT | accumulating spikes, busy high
module spike_rate_decoder #(
   parameter int WIDTH       = 16,
   parameter int WINDOW_SIZE = 5,
   parameter int CNT_WIDTH   = 8,
   parameter int SCALE       = 13107
) (
   input  logic              clk,
   input  logic              rst,
   spike_rate_decoder_if.slave bus
);
   localparam int IDX_W = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
   localparam int PW    = WIDTH + CNT_WIDTH;
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(WINDOW_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [PW-1:0]        RATE_MAX = {{CNT_WIDTH{1'b0}}, {WIDTH{1'b1}}};

   typedef enum logic {IDLE, COUNT} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_WIDTH-1:0] count_out1_q, count_out1_d, count_out2_q, count_out2_d;
   logic [WIDTH-1:0]     rate1_q, rate1_d, rate2_q, rate2_d;
   logic [1:0]           winner_q, winner_d;
   logic                 valid_q, valid_d;
   logic [CNT_WIDTH-1:0] sum1, sum2;

   function automatic logic [WIDTH-1:0] to_rate(input logic [CNT_WIDTH-1:0] c);
      logic [PW-1:0] p;
      p = PW'(c) * PW'(SCALE);
      if (p > RATE_MAX) return {WIDTH{1'b1}};
      return p[WIDTH-1:0];
   endfunction

   function automatic logic [1:0] pick_winner(input logic [CNT_WIDTH-1:0] a,
                                              input logic [CNT_WIDTH-1:0] b);
      if (a == '0 && b == '0) return 2'b00;
      if (a > b)              return 2'b01;
      if (b > a)              return 2'b10;
      return 2'b11;
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt1_d       = cnt1_q;
      cnt2_d       = cnt2_q;
      idx_d        = idx_q;
      count_out1_d = count_out1_q;
      count_out2_d = count_out2_q;
      rate1_d      = rate1_q;
      rate2_d      = rate2_q;
      winner_d     = winner_q;
      valid_d      = 1'b0;
      sum1 = (bus.spike_in1 && cnt1_q != CNT_MAX) ? cnt1_q + CNT_WIDTH'(1) : cnt1_q;
      sum2 = (bus.spike_in2 && cnt2_q != CNT_MAX) ? cnt2_q + CNT_WIDTH'(1) : cnt2_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = COUNT;
               cnt1_d  = '0;
               cnt2_d  = '0;
               idx_d   = '0;
            end
         end
         COUNT: begin
            cnt1_d = sum1;
            cnt2_d = sum2;
            idx_d  = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               // Latch totals including this edge's spikes, then restart or stop.
               count_out1_d = sum1;
               count_out2_d = sum2;
               rate1_d      = to_rate(sum1);
               rate2_d      = to_rate(sum2);
               winner_d     = pick_winner(sum1, sum2);
               valid_d      = 1'b1;
               cnt1_d       = '0;
               cnt2_d       = '0;
               idx_d        = '0;
               state_d      = bus.cont ? COUNT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt1_q       <= '0;
         cnt2_q       <= '0;
         idx_q        <= '0;
         count_out1_q <= '0;
         count_out2_q <= '0;
         rate1_q      <= '0;
         rate2_q      <= '0;
         winner_q     <= 2'b00;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt1_q       <= cnt1_d;
         cnt2_q       <= cnt2_d;
         idx_q        <= idx_d;
         count_out1_q <= count_out1_d;
         count_out2_q <= count_out2_d;
         rate1_q      <= rate1_d;
         rate2_q      <= rate2_d;
         winner_q     <= winner_d;
         valid_q      <= valid_d;
      end
   end

   assign bus.busy       = (state_q == COUNT);
   assign bus.count_out1 = count_out1_q;
   assign bus.count_out2 = count_out2_q;
   assign bus.rate_out1  = rate1_q;
   assign bus.rate_out2  = rate2_q;
   assign bus.winner     = winner_q;
   assign bus.valid      = valid_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: default instance plus a CNT_WIDTH=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_spike_rate_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, cont = 1'b0, s1 = 1'b0, s2 = 1'b0;
   int   n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   spike_rate_decoder_if #(.WIDTH(16), .CNT_WIDTH(8)) bus_a ();
   spike_rate_decoder_if #(.WIDTH(16), .CNT_WIDTH(2)) bus_b ();

   assign bus_a.start = start;  assign bus_b.start = start;
   assign bus_a.cont  = cont;   assign bus_b.cont  = cont;
   assign bus_a.spike_in1 = s1; assign bus_b.spike_in1 = s1;
   assign bus_a.spike_in2 = s2; assign bus_b.spike_in2 = s2;

   spike_rate_decoder #(.WIDTH(16), .WINDOW_SIZE(5), .CNT_WIDTH(8), .SCALE(13107))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   spike_rate_decoder #(.WIDTH(16), .WINDOW_SIZE(5), .CNT_WIDTH(2), .SCALE(13107))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   typedef struct {
      logic [4:0] p1;
      logic [4:0] p2;
      int c1, c2, r1, r2, w;
      bit mid_start;
   } vec_t;
   vec_t vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else n_pass++;
   endtask

   task automatic run_window(input int k);
      vec_t v;
      v = vecs[k];
      cont = 1'b0;
      start = 1'b1;
      tick();
      chk($sformatf("v%0d busy_after_start", k), int'(bus_a.busy), 1);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s1 = v.p1[i];
         s2 = v.p2[i];
         start = v.mid_start && (i == 2 || i == 4);
         tick();
         if (i < 4) chk($sformatf("v%0d early_valid_%0d", k, i), int'(bus_a.valid), 0);
      end
      s1 = 1'b0; s2 = 1'b0; start = 1'b0;
      chk($sformatf("v%0d valid", k), int'(bus_a.valid), 1);
      chk($sformatf("v%0d busy_end", k), int'(bus_a.busy), 0);
      chk($sformatf("v%0d count1", k), int'(bus_a.count_out1), v.c1);
      chk($sformatf("v%0d count2", k), int'(bus_a.count_out2), v.c2);
      chk($sformatf("v%0d rate1", k), int'(bus_a.rate_out1), v.r1);
      chk($sformatf("v%0d rate2", k), int'(bus_a.rate_out2), v.r2);
      chk($sformatf("v%0d winner", k), int'(bus_a.winner), v.w);
      if (k == 0) begin
         chk("sat count1", int'(bus_b.count_out1), 3);
         chk("sat rate1", int'(bus_b.rate_out1), 39321);
         chk("sat count2", int'(bus_b.count_out2), 2);
         chk("sat rate2", int'(bus_b.rate_out2), 26214);
         chk("sat winner", int'(bus_b.winner), 1);
      end
      tick();
      chk($sformatf("v%0d valid_pulse", k), int'(bus_a.valid), 0);
      chk($sformatf("v%0d hold_rate1", k), int'(bus_a.rate_out1), v.r1);
      chk($sformatf("v%0d idle", k), int'(bus_a.busy), 0);
   endtask

   initial begin
      vecs[0] = '{p1: 5'b11111, p2: 5'b00011, c1: 5, c2: 2, r1: 65535, r2: 26214, w: 1, mid_start: 1'b0};
      vecs[1] = '{p1: 5'b00000, p2: 5'b00000, c1: 0, c2: 0, r1: 0,     r2: 0,     w: 0, mid_start: 1'b0};
      vecs[2] = '{p1: 5'b00111, p2: 5'b11100, c1: 3, c2: 3, r1: 39321, r2: 39321, w: 3, mid_start: 1'b0};
      vecs[3] = '{p1: 5'b00000, p2: 5'b01111, c1: 0, c2: 4, r1: 0,     r2: 52428, w: 2, mid_start: 1'b0};
      vecs[4] = '{p1: 5'b10000, p2: 5'b00000, c1: 1, c2: 0, r1: 13107, r2: 0,     w: 1, mid_start: 1'b1};

      // Reset while start and spikes are asserted.
      rst = 1'b1; start = 1'b1; s1 = 1'b1; s2 = 1'b1;
      tick(); tick();
      chk("rst busy", int'(bus_a.busy), 0);
      chk("rst valid", int'(bus_a.valid), 0);
      chk("rst count1", int'(bus_a.count_out1), 0);
      chk("rst rate2", int'(bus_a.rate_out2), 0);
      chk("rst winner", int'(bus_a.winner), 0);
      rst = 1'b0; start = 1'b0; s1 = 1'b0; s2 = 1'b0;
      tick();
      chk("post_rst idle", int'(bus_a.busy), 0);

      for (int k = 0; k < 5; k++) run_window(k);

      // Continuous mode: two gap-free windows.
      cont = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s1 = 1'b0; s2 = (i < 4);
         tick();
         if (i < 4) chk($sformatf("contA early_valid_%0d", i), int'(bus_a.valid), 0);
      end
      chk("contA valid", int'(bus_a.valid), 1);
      chk("contA busy", int'(bus_a.busy), 1);
      chk("contA count1", int'(bus_a.count_out1), 0);
      chk("contA count2", int'(bus_a.count_out2), 4);
      chk("contA rate2", int'(bus_a.rate_out2), 52428);
      chk("contA winner", int'(bus_a.winner), 2);
      cont = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s1 = (i == 0); s2 = 1'b0;
         tick();
         if (i < 4) begin
            chk($sformatf("contB early_valid_%0d", i), int'(bus_a.valid), 0);
            chk($sformatf("contB busy_%0d", i), int'(bus_a.busy), 1);
         end
      end
      s1 = 1'b0;
      chk("contB valid", int'(bus_a.valid), 1);
      chk("contB busy", int'(bus_a.busy), 0);
      chk("contB count1", int'(bus_a.count_out1), 1);
      chk("contB rate1", int'(bus_a.rate_out1), 13107);
      chk("contB count2", int'(bus_a.count_out2), 0);
      chk("contB winner", int'(bus_a.winner), 1);
      tick();

      // Abort a window after three sample edges.
      start = 1'b1;
      tick();
      start = 1'b0; s1 = 1'b1; s2 = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; s1 = 1'b0; s2 = 1'b0;
      chk("abort busy", int'(bus_a.busy), 0);
      chk("abort valid", int'(bus_a.valid), 0);
      chk("abort count1", int'(bus_a.count_out1), 0);
      chk("abort rate1", int'(bus_a.rate_out1), 0);
      chk("abort winner", int'(bus_a.winner), 0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 6; i++) begin
            tick();
            seen += int'(bus_a.valid);
         end
         chk("abort no_valid", seen, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
